ps2_host_tx: RTL and testbench

//  PS/2 host-to-device transmitter; the sending direction of the keyboard link. Sends one

---
 rtl/ps2_host_tx.sv | 157 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Drives ps2c/ps2d open-drain, clocks bits out
// on device-generated falling edges and reports ACK (done) or timeout/NACK (error).
module ps2_host_tx #(
  parameter int unsigned RTS_CYCLES     = 10000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  logic       ps2c,
  inout  logic       ps2d,
  output logic       tx_idle,
  output logic       rx_en,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int unsigned CW = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
  localparam int unsigned WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, RTS, START, DATA, STOP, ACK, WREL} state_t;

  state_t                state, state_n;
  logic [FILTER_LEN-1:0] filt;
  logic                  f_val, f_val_n, fall;
  logic [1:0]            d_sync;
  logic [8:0]            sh, sh_n;
  logic [3:0]            n, n_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [WW-1:0]         wd;
  logic                  timed, timeout;
  logic                  c_low, d_low;
  logic                  done_n, err_n;

  assign ps2c    = c_low ? 1'b0 : 1'bz;
  assign ps2d    = d_low ? 1'b0 : 1'bz;
  assign tx_idle = (state == IDLE);
  assign rx_en   = tx_idle;

  // Filtered clock level only moves when the whole sample window agrees.
  always_comb begin
    f_val_n = f_val;
    if (&filt)
      f_val_n = 1'b1;
    else if (~|filt)
      f_val_n = 1'b0;
  end

  assign timed   = (state inside {START, DATA, STOP, ACK, WREL});
  assign timeout = timed && (wd == WW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      filt         <= '1;
      f_val        <= 1'b1;
      fall         <= 1'b0;
      d_sync       <= '1;
      state        <= IDLE;
      sh           <= '0;
      n            <= '0;
      cnt          <= '0;
      wd           <= '0;
      tx_done_tick <= 1'b0;
      tx_err_tick  <= 1'b0;
    end else begin
      filt         <= {ps2c, filt[FILTER_LEN-1:1]};
      f_val        <= f_val_n;
      fall         <= f_val & ~f_val_n;
      d_sync       <= {d_sync[0], ps2d};
      state        <= state_n;
      sh           <= sh_n;
      n            <= n_n;
      cnt          <= cnt_n;
      tx_done_tick <= done_n;
      tx_err_tick  <= err_n;
      if (!timed || fall || (state_n != state))
        wd <= '0;
      else
        wd <= wd + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    n_n     = n;
    cnt_n   = cnt;
    c_low   = 1'b0;
    d_low   = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_ps2) begin
          sh_n    = {~^din, din};
          n_n     = 4'd8;
          cnt_n   = CW'(RTS_CYCLES - 1);
          state_n = RTS;
        end
      end
      RTS: begin
        c_low = 1'b1;
        if (cnt == '0)
          state_n = START;
        else
          cnt_n = cnt - 1'b1;
      end
      START: begin
        d_low = 1'b1;
        if (fall)
          state_n = DATA;
      end
      DATA: begin
        d_low = ~sh[0];
        if (fall) begin
          sh_n = {1'b0, sh[8:1]};
          if (n == 4'd0)
            state_n = STOP;
          else
            n_n = n - 4'd1;
        end
      end
      STOP: begin
        if (fall)
          state_n = ACK;
      end
      ACK: begin
        if (fall) begin
          if (d_sync[1]) begin
            err_n   = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WREL;
          end
        end
      end
      WREL: begin
        if (f_val && d_sync[1]) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Watchdog expiry overrides whatever the state decided, so done/err stay exclusive.
    if (timeout) begin
      state_n = IDLE;
      c_low   = 1'b0;
      d_low   = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and
// compares the sampled bits against a frame model built from the byte value.
module tb_ps2_host_tx;

  localparam int RTS = 40;
  localparam int FL  = 8;
  localparam int TO  = 1500;
  localparam int H   = 25;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle, rx_en, tx_done_tick, tx_err_tick;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_host_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .wr_ps2(wr_ps2), .din(din), .ps2c(ps2c), .ps2d(ps2d),
    .tx_idle(tx_idle), .rx_en(rx_en), .tx_done_tick(tx_done_tick), .tx_err_tick(tx_err_tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) n_done++;
    if (tx_err_tick === 1'b1) n_err++;
    if (tx_done_tick === 1'b1 && tx_err_tick === 1'b1) n_both++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "time limit");
  end

  // Frame as seen by the device: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    wr_ps2 = 1'b1;
    din    = b;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // mode: 0 = ACK, 1 = ps2c glitch after pulse 3, 2 = stray wr_ps2 after pulse 4, 3 = NACK
  task automatic device(input int mode, input int pulses, output logic [10:0] got,
                        output int rts_len);
    got = '1;
    rts_len = 0;
    while (ps2c === 1'b0 && rts_len < 10 * RTS) begin
      rts_len++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    got[0] = ps2d;
    repeat (2 * H - 4) @(negedge clk);
    for (int i = 1; i <= pulses; i++) begin
      dev_c_low = 1'b1;
      repeat (H) @(negedge clk);
      if (i <= 10) got[i] = ps2d;
      dev_c_low = 1'b0;
      if (i == 10 && mode != 3) dev_d_low = 1'b1;
      if (i == 3 && mode == 1) begin
        repeat (5) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (FL - 1) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (H - 5 - (FL - 1)) @(negedge clk);
      end else if (i == 4 && mode == 2) begin
        repeat (5) @(negedge clk);
        wr_ps2 = 1'b1;
        din    = 8'h55;
        @(negedge clk);
        wr_ps2 = 1'b0;
        repeat (H - 6) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
    end
    dev_d_low = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (tx_idle !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (k >= 400) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no return to idle within 400 cycles", name);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input int mode,
                           input logic [10:0] want);
    logic [10:0] got;
    int          rl, d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(b);
    device(mode, 12, got, rl);
    wait_idle(name);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s frame: got %b want %b", name, got, want);
    end
    n_cmp++;
    if (rl !== RTS) begin
      n_bad++;
      $display("FAIL %s rts_len: got %0d want %0d", name, rl, RTS);
    end
    n_cmp++;
    if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
      n_bad++;
      $display("FAIL %s ticks: done %0d err %0d want 1 0", name, n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({tx_idle, rx_en, tx_done_tick, tx_err_tick, ps2c, ps2d} !== 6'b110011) begin
      n_bad++;
      $display("FAIL reset_state: got %b want 110011",
               {tx_idle, rx_en, tx_done_tick, tx_err_tick, ps2c, ps2d});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_ed;
    logic [10:0] got;
    int          rl, d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(8'hED);
    n_cmp++;
    if ({tx_idle, rx_en, ps2c} !== 3'b000) begin
      n_bad++;
      $display("FAIL latency: idle/rx_en/ps2c got %b want 000", {tx_idle, rx_en, ps2c});
    end
    device(0, 12, got, rl);
    wait_idle("frame_ed");
    n_cmp++;
    if (rl !== RTS) begin
      n_bad++;
      $display("FAIL ed_rts_len: got %0d want %0d", rl, RTS);
    end
    n_cmp++;
    if (got !== 11'b11111011010) begin
      n_bad++;
      $display("FAIL ed_frame: got %b want 11111011010", got);
    end
    n_cmp++;
    if ((n_done - d0) !== 1 || (n_err - e0) !== 0) begin
      n_bad++;
      $display("FAIL ed_ticks: done %0d err %0d want 1 0", n_done - d0, n_err - e0);
    end
  endtask

  task automatic test_parity;
    logic [7:0] vals [3];
    logic       pars [3];
    logic [10:0] got;
    int          rl;
    vals = '{8'h00, 8'h01, 8'hFF};
    pars = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send(vals[i]);
      device(0, 12, got, rl);
      wait_idle("parity");
      n_cmp++;
      if (got[9] !== pars[i]) begin
        n_bad++;
        $display("FAIL parity_%02h: got %b want %b", vals[i], got[9], pars[i]);
      end
      n_cmp++;
      if (got[8:1] !== vals[i]) begin
        n_bad++;
        $display("FAIL parity_data_%02h: got %02h want %02h", vals[i], got[8:1], vals[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] b;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      run_frame("random", b, 0, frame_of(b));
    end
  endtask

  task automatic test_timeout;
    int k, e, d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(8'h3C);
    k = 0;
    while (ps2c === 1'b0 && k < 10 * RTS) begin
      @(negedge clk);
      k++;
    end
    e = 0;
    while (tx_err_tick !== 1'b1 && e < TO + 100) begin
      @(negedge clk);
      e++;
    end
    n_cmp++;
    if (e < TO || e > TO + 2) begin
      n_bad++;
      $display("FAIL timeout_delay: got %0d cycles want %0d..%0d", e, TO, TO + 2);
    end
    n_cmp++;
    if ({ps2c, ps2d, tx_idle} !== 3'b111) begin
      n_bad++;
      $display("FAIL timeout_lines: ps2c/ps2d/idle got %b want 111", {ps2c, ps2d, tx_idle});
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if ((n_err - e0) !== 1 || (n_done - d0) !== 0) begin
      n_bad++;
      $display("FAIL timeout_ticks: err %0d done %0d want 1 0", n_err - e0, n_done - d0);
    end
  endtask

  task automatic test_nack;
    logic [10:0] got;
    int          rl, d0, e0;
    d0 = n_done;
    e0 = n_err;
    send(8'hA7);
    device(3, 12, got, rl);
    wait_idle("nack");
    n_cmp++;
    if ((n_err - e0) !== 1 || (n_done - d0) !== 0 || tx_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL nack: err %0d done %0d idle %b want 1 0 1", n_err - e0, n_done - d0, tx_idle);
    end
    n_cmp++;
    if (got !== frame_of(8'hA7)) begin
      n_bad++;
      $display("FAIL nack_frame: got %b want %b", got, frame_of(8'hA7));
    end
  endtask

  task automatic test_ignore_wr;
    run_frame("ignore_wr", 8'hED, 2, frame_of(8'hED));
  endtask

  task automatic test_glitch;
    run_frame("glitch", 8'hED, 1, frame_of(8'hED));
  endtask

  task automatic test_reset_mid;
    logic [10:0] got;
    int          rl, d0, e0;
    send(8'h00);
    device(0, 5, got, rl);
    n_cmp++;
    if ({tx_idle, rx_en, ps2d} !== 3'b000) begin
      n_bad++;
      $display("FAIL mid_data: idle/rx_en/ps2d got %b want 000", {tx_idle, rx_en, ps2d});
    end
    d0 = n_done;
    e0 = n_err;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ps2c, ps2d, tx_idle, rx_en} !== 4'b1111) begin
      n_bad++;
      $display("FAIL reset_mid: ps2c/ps2d/idle/rx_en got %b want 1111",
               {ps2c, ps2d, tx_idle, rx_en});
    end
    reset = 1'b0;
    repeat (4 * H) @(negedge clk);
    n_cmp++;
    if ((n_done - d0) !== 0 || (n_err - e0) !== 0 || tx_idle !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_ticks: done %0d err %0d idle %b want 0 0 1",
               n_done - d0, n_err - e0, tx_idle);
    end
  endtask

  task automatic test_recover;
    run_frame("recover", 8'hFF, 0, frame_of(8'hFF));
  endtask

  task automatic test_exclusive;
    n_cmp++;
    if (n_both !== 0) begin
      n_bad++;
      $display("FAIL exclusive_ticks: got %0d overlapping cycles want 0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_frame_ed();
    test_parity();
    test_random();
    test_timeout();
    test_nack();
    test_ignore_wr();
    test_glitch();
    test_reset_mid();
    test_recover();
    test_exclusive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
